ram_port_arbiter: RTL and testbench

//  Shares the single-port data RAM between instruction fetch (I) and load/store (D) requesters.

---
 rtl/ram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one data RAM port between fetch (I) and LSU (D).
// Checks alignment/range, drives the RAM, registers responses, counts stalls.
module ram_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    output logic             i_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [2:0]       d_access,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_err,
    output logic             ram_load,
    output logic             ram_store,
    output logic [2:0]       ram_access,
    output logic [31:0]      ram_addr,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] i_stall_cnt,
    output logic [CNT_W-1:0] d_stall_cnt
);

    localparam int HI = ADDR_W + 2;

    logic             last_d_q;
    logic             i_oor, d_oor;
    logic             i_bad, d_bad;
    logic             i_rvalid_q, d_rvalid_q;
    logic             i_err_q, d_err_q;
    logic [31:0]      i_rdata_q, d_rdata_q;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

    // Grant the lone requester; on a tie grant the port that did not win last.
    // Grants are masked while reset is held so every output reads 0.
    always_comb begin
        i_gnt = rst & i_req & (~d_req | last_d_q);
        d_gnt = rst & d_req & (~i_req | ~last_d_q);
    end

    // Out-of-range and alignment/encoding checks for both ports.
    always_comb begin
        i_oor = |(i_addr >> HI);
        d_oor = |(d_addr >> HI);
        i_bad = i_oor | (i_addr[1:0] != 2'b00);
        d_bad = d_oor;
        unique case (d_access)
            3'b000:  d_bad = d_oor;
            3'b001:  d_bad = d_oor | d_addr[0];
            3'b010:  d_bad = d_oor | (d_addr[1:0] != 2'b00);
            3'b100:  d_bad = d_oor | d_we;
            3'b101:  d_bad = d_oor | d_we | d_addr[0];
            default: d_bad = 1'b1;
        endcase
    end

    // Route the winner's payload to the RAM; erroring accesses never strobe it.
    always_comb begin
        ram_load   = 1'b0;
        ram_store  = 1'b0;
        ram_access = 3'b000;
        ram_addr   = 32'h0;
        ram_wdata  = 32'h0;
        if (i_gnt) begin
            ram_load   = ~i_bad;
            ram_access = 3'b010;
            ram_addr   = i_addr;
        end else if (d_gnt) begin
            ram_load   = ~d_we & ~d_bad;
            ram_store  = d_we & ~d_bad;
            ram_access = d_access;
            ram_addr   = d_addr;
            ram_wdata  = d_wdata;
        end
    end

    // Saturating stall counters; a clear beats the increment.
    always_comb begin
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        if (stat_clr) begin
            i_cnt_d = '0;
            d_cnt_d = '0;
        end else begin
            if (i_req && !i_gnt && i_cnt_q != '1)
                i_cnt_d = i_cnt_q + CNT_W'(1);
            if (d_req && !d_gnt && d_cnt_q != '1)
                d_cnt_d = d_cnt_q + CNT_W'(1);
        end
    end

    // Round-robin pointer, one-cycle responses and stall counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q   <= 1'b1;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= 32'h0;
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
        end else begin
            if (i_gnt)
                last_d_q <= 1'b0;
            else if (d_gnt)
                last_d_q <= 1'b1;
            i_rvalid_q <= i_gnt;
            i_err_q    <= i_gnt & i_bad;
            i_rdata_q  <= (i_gnt && !i_bad) ? ram_rdata : 32'h0;
            d_rvalid_q <= d_gnt;
            d_err_q    <= d_gnt & d_bad;
            d_rdata_q  <= (d_gnt && !d_we && !d_bad) ? ram_rdata : 32'h0;
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
        end
    end

    assign i_rvalid    = i_rvalid_q;
    assign i_err       = i_err_q;
    assign i_rdata     = i_rdata_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;
    assign i_stall_cnt = i_cnt_q;
    assign d_stall_cnt = d_cnt_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed vectors,
// per-port response queues drained by an independent monitor.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_req;
    logic [31:0]      i_addr;
    logic             i_gnt, i_rvalid, i_err;
    logic [31:0]      i_rdata;
    logic             d_req, d_we;
    logic [2:0]       d_access;
    logic [31:0]      d_addr, d_wdata;
    logic             d_gnt, d_rvalid, d_err;
    logic [31:0]      d_rdata;
    logic             ram_load, ram_store;
    logic [2:0]       ram_access;
    logic [31:0]      ram_addr, ram_wdata, ram_rdata;
    logic             stat_clr;
    logic [CNT_W-1:0] i_stall_cnt, d_stall_cnt;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t iq[$];
    rsp_t dq[$];
    int   total = 0;
    int   bad   = 0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_access(d_access),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_load(ram_load), .ram_store(ram_store),
        .ram_access(ram_access), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stat_clr(stat_clr),
        .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: byte addressed, combinational read, write on edge.
    logic [31:0] mem [0:2047];
    logic [31:0] word;
    logic [7:0]  bt;
    logic [15:0] hw;

    always_comb begin
        word = mem[ram_addr[12:2]];
        bt   = word[{ram_addr[1:0], 3'b000} +: 8];
        hw   = ram_addr[1] ? word[31:16] : word[15:0];
        case (ram_access)
            3'b000:  ram_rdata = {{24{bt[7]}}, bt};
            3'b100:  ram_rdata = {24'h0, bt};
            3'b001:  ram_rdata = {{16{hw[15]}}, hw};
            3'b101:  ram_rdata = {16'h0, hw};
            default: ram_rdata = word;
        endcase
    end

    always @(posedge clk) begin
        if (ram_store) begin
            case (ram_access)
                3'b000: mem[ram_addr[12:2]][{ram_addr[1:0], 3'b000} +: 8] <= ram_wdata[7:0];
                3'b001: mem[ram_addr[12:2]][{ram_addr[1], 4'b0000} +: 16] <= ram_wdata[15:0];
                default: mem[ram_addr[12:2]] <= ram_wdata;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [2:0] dac,
                       input logic [31:0] da, input logic [31:0] dw);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_access = dac; d_addr = da; d_wdata = dw;
        @(negedge clk);
    endtask

    // Monitor: every presented response must match the oldest expected one.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (i_rvalid) begin
                total++;
                if (iq.size() == 0) begin
                    bad++;
                    $display("FAIL i_unexpected got=rvalid want=none");
                end else begin
                    r = iq.pop_front();
                    chk("i_rdata", i_rdata, r.data);
                    chk("i_err", {31'h0, i_err}, {31'h0, r.err});
                end
            end
            if (d_rvalid) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL d_unexpected got=rvalid want=none");
                end else begin
                    r = dq.pop_front();
                    chk("d_rdata", d_rdata, r.data);
                    chk("d_err", {31'h0, d_err}, {31'h0, r.err});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ie, de;
        for (int k = 0; k < 2048; k++) mem[k] = 32'h1000_0000 + k;
        rst = 1'b0; stat_clr = 1'b0;
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_access = 3'b010;
        d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_i_gnt", {31'h0, i_gnt}, 32'h0);
        chk("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
        chk("rst_ram_load", {31'h0, ram_load}, 32'h0);
        chk("rst_i_rvalid", {31'h0, i_rvalid}, 32'h0);
        chk("rst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("rst_i_cnt", {28'h0, i_stall_cnt}, 32'h0);
        chk("rst_d_cnt", {28'h0, d_stall_cnt}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;

        // fetch-only stream, one response per cycle
        for (int k = 0; k < 3; k++) begin
            cyc(1, 32'h8, 0, 0, 3'b000, 0, 0);
            chk("t1_i_gnt", {31'h0, i_gnt}, 32'h1);
            chk("t1_d_gnt", {31'h0, d_gnt}, 32'h0);
            chk("t1_ram_load", {31'h0, ram_load}, 32'h1);
            chk("t1_ram_access", {29'h0, ram_access}, 32'h2);
            chk("t1_ram_addr", ram_addr, 32'h8);
            iq.push_back('{32'h1000_0002, 1'b0});
        end
        cyc(0, 0, 0, 0, 3'b000, 0, 0);
        chk("idle_i_gnt", {31'h0, i_gnt}, 32'h0);
        chk("idle_ram_load", {31'h0, ram_load}, 32'h0);
        chk("idle_ram_addr", ram_addr, 32'h0);

        // byte store then loads, back to back
        cyc(0, 0, 1, 1, 3'b000, 32'h5, 32'hAB);
        chk("sb_d_gnt", {31'h0, d_gnt}, 32'h1);
        chk("sb_ram_store", {31'h0, ram_store}, 32'h1);
        chk("sb_ram_wdata", ram_wdata, 32'hAB);
        dq.push_back('{32'h0, 1'b0});
        cyc(0, 0, 1, 0, 3'b100, 32'h5, 0);
        chk("lbu_ram_load", {31'h0, ram_load}, 32'h1);
        dq.push_back('{32'h0000_00AB, 1'b0});
        cyc(0, 0, 1, 0, 3'b010, 32'h4, 0);
        dq.push_back('{32'h1000_AB01, 1'b0});
        cyc(0, 0, 1, 1, 3'b000, 32'h9, 32'h80);
        dq.push_back('{32'h0, 1'b0});
        cyc(0, 0, 1, 0, 3'b000, 32'h9, 0);
        dq.push_back('{32'hFFFF_FF80, 1'b0});

        // error cases: still granted, RAM untouched
        cyc(0, 0, 1, 0, 3'b010, 32'h6, 0);
        chk("lw6_d_gnt", {31'h0, d_gnt}, 32'h1);
        chk("lw6_ram_load", {31'h0, ram_load}, 32'h0);
        dq.push_back('{32'h0, 1'b1});
        cyc(1, 32'h2000, 0, 0, 3'b000, 0, 0);
        chk("oor_i_gnt", {31'h0, i_gnt}, 32'h1);
        chk("oor_ram_load", {31'h0, ram_load}, 32'h0);
        iq.push_back('{32'h0, 1'b1});
        cyc(1, 32'h2, 0, 0, 3'b000, 0, 0);
        iq.push_back('{32'h0, 1'b1});
        cyc(0, 0, 1, 1, 3'b101, 32'h10, 32'h1234);
        chk("shu_ram_store", {31'h0, ram_store}, 32'h0);
        dq.push_back('{32'h0, 1'b1});
        cyc(0, 0, 1, 0, 3'b011, 32'h0, 0);
        dq.push_back('{32'h0, 1'b1});
        cyc(0, 0, 1, 0, 3'b001, 32'h3, 0);
        dq.push_back('{32'h0, 1'b1});
        cyc(0, 0, 1, 0, 3'b101, 32'h2, 0);
        dq.push_back('{32'h0000_1000, 1'b0});

        // reset just after a grant: its response must vanish
        cyc(0, 0, 1, 0, 3'b010, 32'h10, 0);
        chk("pre_rst_d_gnt", {31'h0, d_gnt}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'hC;
        d_req = 1'b1; d_we = 1'b0; d_access = 3'b010; d_addr = 32'h10;
        @(negedge clk);
        chk("mid_rst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        chk("mid_rst_i_gnt", {31'h0, i_gnt}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // both requesting: strict alternation from I, counters saturate
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            ie = (k / 2 > 15) ? 15 : k / 2;
            de = ((k + 1) / 2 > 15) ? 15 : (k + 1) / 2;
            chk("rr_i_gnt", {31'h0, i_gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_d_gnt", {31'h0, d_gnt}, (k % 2 == 1) ? 32'h1 : 32'h0);
            chk("rr_i_cnt", {28'h0, i_stall_cnt}, ie);
            chk("rr_d_cnt", {28'h0, d_stall_cnt}, de);
            if (k % 2 == 0) iq.push_back('{32'h1000_0003, 1'b0});
            else dq.push_back('{32'h1000_0004, 1'b0});
            @(posedge clk);
            #1;
        end
        stat_clr = 1'b1;
        @(negedge clk);
        chk("clr_i_gnt", {31'h0, i_gnt}, 32'h1);
        chk("sat_d_cnt", {28'h0, d_stall_cnt}, 32'hF);
        chk("sat_i_cnt", {28'h0, i_stall_cnt}, 32'hF);
        iq.push_back('{32'h1000_0003, 1'b0});
        @(posedge clk);
        #1;
        stat_clr = 1'b0; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("clr_i_cnt", {28'h0, i_stall_cnt}, 32'h0);
        chk("clr_d_cnt", {28'h0, d_stall_cnt}, 32'h0);
        cyc(0, 0, 0, 0, 3'b000, 0, 0);
        chk("hold_d_cnt", {28'h0, d_stall_cnt}, 32'h0);

        repeat (3) @(negedge clk);
        chk("i_queue_left", iq.size(), 32'h0);
        chk("d_queue_left", dq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
